// File: rtl/comb_inverse.sv
// comb_inverse: FIR inverse of a feedback comb on I/Q, out = y[n] + y[n-D] - (y[n-D] >>> S),
// with a primed delay line and saturation to the sample width.
module comb_inverse #(
    parameter int BIT_WIDTH  = 16,
    parameter int DELAY_LOG2 = 3,
    parameter int FB_SHIFT   = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        strobe_in,
    input  logic signed [BIT_WIDTH-1:0] i_in,
    input  logic signed [BIT_WIDTH-1:0] q_in,
    output logic                        strobe_out,
    output logic signed [BIT_WIDTH-1:0] i_out,
    output logic signed [BIT_WIDTH-1:0] q_out,
    output logic                        primed
);
    localparam int D = 1 << DELAY_LOG2;

    logic signed [BIT_WIDTH-1:0] r_ram_i [D];
    logic signed [BIT_WIDTH-1:0] r_ram_q [D];
    logic [DELAY_LOG2-1:0]       r_ptr;
    logic [DELAY_LOG2:0]         r_cnt;
    logic signed [BIT_WIDTH-1:0] w_di;
    logic signed [BIT_WIDTH-1:0] w_dq;

    function automatic logic signed [BIT_WIDTH-1:0] equalize(
        input logic signed [BIT_WIDTH-1:0] y,
        input logic signed [BIT_WIDTH-1:0] d
    );
        logic signed [BIT_WIDTH+1:0] s;
        s = (BIT_WIDTH+2)'(y) + (BIT_WIDTH+2)'(d) - ((BIT_WIDTH+2)'(d) >>> FB_SHIFT);
        return (s[BIT_WIDTH+1:BIT_WIDTH-1] == '0 || s[BIT_WIDTH+1:BIT_WIDTH-1] == '1)
            ? s[BIT_WIDTH-1:0]
            : {s[BIT_WIDTH+1], {(BIT_WIDTH-1){~s[BIT_WIDTH+1]}}};
    endfunction

    // The counter saturates at D, so its MSB alone marks a full delay line.
    assign primed = r_cnt[DELAY_LOG2];
    assign w_di   = primed ? r_ram_i[r_ptr] : '0;
    assign w_dq   = primed ? r_ram_q[r_ptr] : '0;

    always_ff @(posedge clock) begin
        if (strobe_in) begin
            r_ram_i[r_ptr] <= i_in;
            r_ram_q[r_ptr] <= q_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            strobe_out <= 1'b0;
            i_out      <= '0;
            q_out      <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
        end else begin
            strobe_out <= strobe_in;
            if (strobe_in) begin
                r_ptr <= r_ptr + 1'b1;
                r_cnt <= primed ? r_cnt : r_cnt + 1'b1;
                i_out <= equalize(i_in, w_di);
                q_out <= equalize(q_in, w_dq);
            end
        end
    end
endmodule

// File: doc/comb_inverse.md
COMB_INVERSE -- requirements
Module: comb_inverse

Interface
REQ-001 Parameter BIT_WIDTH, default 16: signed I/Q sample width.
REQ-002 Parameter DELAY_LOG2, default 3: comb delay D = 2^DELAY_LOG2 samples.
REQ-003 Parameter FB_SHIFT, default 3: feedback attenuation shift S; gain g = 1 - 2^-S.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 strobe_in  input  1  qualifies i_in/q_in as one sample for the current cycle.
REQ-007 i_in  input  BIT_WIDTH  signed in-phase sample, the output of the feedback comb.
REQ-008 q_in  input  BIT_WIDTH  signed quadrature sample, the output of the feedback comb.
REQ-009 strobe_out  output  1  one-cycle pulse; marks i_out/q_out as valid.
REQ-010 i_out  output  BIT_WIDTH  signed equalized in-phase sample.
REQ-011 q_out  output  BIT_WIDTH  signed equalized quadrature sample.
REQ-012 primed  output  1  high once the delay line holds D real samples.

Function
REQ-013 Block SHALL implement the FIR inverse of the feedback comb: out[n] = y[n] + y[n-D] - (y[n-D] >>> S), applied independently to I and Q.
REQ-014 ">>>" SHALL be an arithmetic right shift that rounds toward negative infinity (floor).
REQ-015 The sum SHALL be computed at BIT_WIDTH+2 bits, sign-extended, then saturated to the signed BIT_WIDTH range [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1].
REQ-016 Delay line SHALL be two D-entry RAMs (I and Q) of raw input samples, indexed by a DELAY_LOG2-bit write pointer.
REQ-017 On strobe_in: read the entry at the pointer as y[n-D], write the current input to the same entry, then increment the pointer modulo D. The wrap from D-1 to 0 SHALL be seamless.
REQ-018 Pointer, RAM and prime counter SHALL NOT change in cycles where strobe_in is low. Gaps of any length SHALL be transparent to the arithmetic.
REQ-019 Latency: i_out/q_out SHALL be registered and valid, with strobe_out high, exactly 1 cycle after the strobe_in cycle.
REQ-020 strobe_out SHALL be low in every other cycle.
REQ-021 i_out/q_out SHALL hold their last value between strobes.
REQ-022 Back-to-back strobe_in on every cycle SHALL be supported at full rate.
REQ-023 A prime counter SHALL count strobes from 0 to D and saturate at D.
REQ-024 While the prime counter is < D, y[n-D] SHALL be forced to 0 and the RAM contents ignored, so the RAM needs no reset.
REQ-025 primed SHALL rise in the cycle after the D-th accepted strobe and stay high until reset.
REQ-026 The D+1-th strobe SHALL be the first to use real delayed data.
REQ-027 I and Q paths SHALL share the pointer, prime counter and strobe timing, so they never skew.

Reset
REQ-028 While reset is high: strobe_out=0, i_out=0, q_out=0, primed=0, pointer=0, prime counter=0.
REQ-029 Reset asserted mid-stream SHALL take effect asynchronously and discard any in-flight sample; no strobe_out SHALL appear for a strobe_in coincident with reset.
REQ-030 After reset deasserts, the first strobe_in SHALL be treated as sample n=0 with priming restarted.

Verification (D=8, S=3, BIT_WIDTH=16)
REQ-031 Impulse: i_in=1000 on strobe 0, then 0 on strobes 1..15 -> i_out=1000 at strobe 0, 0 at strobes 1..7, 875 at strobe 8, 0 after; q_out=0 throughout.
REQ-032 Step: constant q_in=-1000 -> q_out=-1000 for strobes 0..7, then -1875 from strobe 8 on; primed rises one cycle after strobe 7.
REQ-033 Saturation: constant i_in=30000 -> 32767 from strobe 8. Constant i_in=-32768 -> -32768 from strobe 8 (raw -61440 clipped).
REQ-034 Gapped strobes: the impulse test with 0-5 random idle cycles between strobes -> identical output sequence; strobe_out lags each strobe_in by exactly 1 cycle.
REQ-035 Reset mid-stream: assert reset after strobe 5 of the step test with RAM holding nonzero data -> outputs 0 immediately; restart yields exactly the REQ-032 sequence.
REQ-036 Round trip: the feedback comb (same parameters) feeding comb_inverse with random small-amplitude I/Q -> output equals the original input within ±2 LSB once primed.
